// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: default width, opcodes and FSM states.
// The MUL state exists only when ALU_SEQ_MUL_EN is defined.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        S_MUL  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per step, WIDTH steps.
// Present only when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    // product is the accumulator after the current step, so the owner can
    // capture the final value on the same edge as the last step.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU feeding an accumulator: single-cycle logic ops, optional
// iterative multiply (ALU_SEQ_MUL_EN). Result and flags are registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] dr_in,
    output logic [WIDTH-1:0] result,
    output logic             ac_we,
    output logic             busy,
    output logic             done,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic             err
);

    state_t           state, state_next;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept;

    logic [WIDTH-1:0] exec_res;
    logic             exec_c, exec_err;

    logic             load_en;
    logic [WIDTH-1:0] load_res;
    logic             load_c, load_err;

    assign accept = (state == S_IDLE) && start;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_last;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .clear_n (clear_n),
        .load    (accept && (op_t'(op) == OP_MUL)),
        .step    (state == S_MUL),
        .a       (ac_in),
        .b       (dr_in),
        .product (mul_product),
        .last    (mul_last)
    );
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_SEQ_MUL_EN
                    state_next = (op_t'(op) == OP_MUL) ? S_MUL : S_EXEC;
`else
                    state_next = S_EXEC;
`endif
                end
            end
            S_EXEC: state_next = S_DONE;
`ifdef ALU_SEQ_MUL_EN
            S_MUL:  if (mul_last) state_next = S_DONE;
`endif
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
        ac_we = (state == S_DONE);
    end

    // Without the multiplier, MUL falls through to the default arm: A passes, err set.
    always_comb begin
        exec_res = a_q;
        exec_c   = 1'b0;
        exec_err = 1'b0;
        case (op_q)
            OP_ADD: {exec_c, exec_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                exec_res = a_q - b_q;
                exec_c   = (a_q < b_q);
            end
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
            OP_SHL: begin
                exec_res = {a_q[WIDTH-2:0], 1'b0};
                exec_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                exec_res = {1'b0, a_q[WIDTH-1:1]};
                exec_c   = a_q[0];
            end
            default: exec_err = 1'b1;
        endcase
    end

    always_comb begin
        load_en  = (state == S_EXEC);
        load_res = exec_res;
        load_c   = exec_c;
        load_err = exec_err;
`ifdef ALU_SEQ_MUL_EN
        if (state == S_MUL && mul_last) begin
            load_en  = 1'b1;
            load_res = mul_product[WIDTH-1:0];
            load_c   = |mul_product[2*WIDTH-1:WIDTH];
            load_err = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            c_flag <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_t'(op);
                a_q  <= ac_in;
                b_q  <= dr_in;
            end
            if (load_en) begin
                result <= load_res;
                z_flag <= (load_res == '0);
                n_flag <= load_res[WIDTH-1];
                c_flag <= load_c;
                err    <= load_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor pops on ac_we.
// Follows ALU_SEQ_MUL_EN to pick the expected MUL behaviour.
module tb_alu_seq;

    localparam int unsigned W = 16;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [W-1:0]  ac_in = '0;
    logic [W-1:0]  dr_in = '0;
    logic [W-1:0]  result;
    logic          ac_we, busy, done, z_flag, n_flag, c_flag, err;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (start),
        .op      (op),
        .ac_in   (ac_in),
        .dr_in   (dr_in),
        .result  (result),
        .ac_we   (ac_we),
        .busy    (busy),
        .done    (done),
        .z_flag  (z_flag),
        .n_flag  (n_flag),
        .c_flag  (c_flag),
        .err     (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned passed = 0;
    int unsigned total  = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         z, n, c, err;
        int unsigned  due;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input int unsigned o, input int unsigned a, input int unsigned b);
        exp_t e;
        longint unsigned p;
        int unsigned r;
        e.c = 1'b0;
        e.err = 1'b0;
        e.due = 0;
        r = 0;
        case (o)
            0: begin r = a + b; e.c = (r > 32'hFFFF); end
            1: begin r = a - b; e.c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a * 2; e.c = (a >= 32'h8000); end
            6: begin r = a / 2; e.c = ((a % 2) == 1); end
            default: begin
                if (MUL_ON) begin
                    p = longint'(a) * longint'(b);
                    r = 32'(p);
                    e.c = (p > 64'hFFFF);
                end else begin
                    r = a;
                    e.err = 1'b1;
                end
            end
        endcase
        e.res = r[W-1:0];
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (clear_n === 1'b1 && (done === 1'b1 || ac_we === 1'b1)) begin
            exp_t e;
            chk("ac_we_eq_done", {31'b0, ac_we}, {31'b0, done});
            if (sb.size() == 0) begin
                total++;
                $display("FAIL spurious_ac_we: got strobe at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", {16'b0, result}, {16'b0, e.res});
                chk("z_flag", {31'b0, z_flag}, {31'b0, e.z});
                chk("n_flag", {31'b0, n_flag}, {31'b0, e.n});
                chk("c_flag", {31'b0, c_flag}, {31'b0, e.c});
                chk("err",    {31'b0, err},    {31'b0, e.err});
                chk("latency", cyc, e.due);
            end
        end
    end

    // Entered and left at a negedge; start is presented immediately.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit repulse);
        exp_t e;
        int unsigned n;
        bit seen, busy_ok;
        e = model(o, a, b);
        e.due = cyc + 1 + ((o == 3'd7 && MUL_ON) ? W : 1);
        sb.push_back(e);
        start = 1'b1; op = o; ac_in = a; dr_in = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); ac_in = W'($urandom); dr_in = W'($urandom);
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 3 * W) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = repulse;
        end
        chk("completed", {31'b0, seen}, 32'd1);
        chk("busy_while_running", {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("done_single_pulse", {31'b0, done}, 32'd0);
        chk("idle_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic abort_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int unsigned wait_n);
        start = 1'b1; op = o; ac_in = a; dr_in = b;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (wait_n) @(posedge clk);
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        chk("abort_outputs_zero",
            {20'b0, result[7:0] | result[15:8], z_flag, n_flag, c_flag, err, ac_we, done, busy},
            32'd0);
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] hold_val;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state",
            {16'b0, result, 1'b0} | {25'b0, z_flag, n_flag, c_flag, err, ac_we, done, busy},
            32'd0);
        clear_n = 1'b1;

        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0);
        hold_val = result;
        repeat (3) @(negedge clk);
        chk("result_holds", {16'b0, result}, {16'b0, hold_val});
        run_op(3'd1, 16'h0003, 16'h0005, 1'b0);
        run_op(3'd7, 16'h0100, 16'h0101, 1'b0);
        run_op(3'd7, 16'h1234, 16'h0002, 1'b0);
        run_op(3'd7, 16'h00FF, 16'h00FF, 1'b1);
        run_op(3'd5, 16'h8001, 16'h5A5A, 1'b0);

        abort_op(3'd7, 16'h1234, 16'h5678, MUL_ON ? 7 : 0);
        run_op(3'd0, 16'h0002, 16'h0003, 1'b0);
        abort_op(3'd0, 16'h4444, 16'h1111, 0);
        run_op(3'd6, 16'h8003, 16'h0000, 1'b0);
        run_op(3'd4, 16'hF0F0, 16'hFF00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0));
        end

        repeat (W + 4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
